traffic_phase_sched: RTL

//  Phase scheduler for the four-approach intersection: arbitrates vehicle requests

---
 rtl/traffic_phase_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/traffic_phase_sched.sv
// Phase scheduler for the four-approach intersection: arbitrates NS/SN/EW/WE requests
// into green/yellow phases and selects servo speed from per-approach congestion.
//
// state   | meaning
// ALL_RED | post-reset clearance, all barriers closed
// G0 / Y0 | NS+SN green / yellow
// G1 / Y1 | EW green / yellow
// G2 / Y2 | WE green / yellow
module traffic_phase_sched #(
    parameter int T_GREEN_MIN = 50,
    parameter int T_GREEN_MAX = 200,
    parameter int T_YELLOW    = 30,
    parameter int T_CONGEST   = 100,
    parameter int TW          = 8
) (
    input  logic       clk_10Hz,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [5:0] tfst,
    output logic [1:0] vel
);

    // State encodings are the light word itself, so tfst needs no decode.
    typedef enum logic [5:0] {
        ALL_RED = 6'b000000,
        G0      = 6'b100000,
        Y0      = 6'b010000,
        G1      = 6'b001000,
        Y1      = 6'b000100,
        G2      = 6'b000010,
        Y2      = 6'b000001
    } state_t;

    localparam logic [TW:0]   L_GMIN = (TW+1)'(T_GREEN_MIN);
    localparam logic [TW:0]   L_GMAX = (TW+1)'(T_GREEN_MAX);
    localparam logic [TW:0]   L_YEL  = (TW+1)'(T_YELLOW);
    localparam logic [TW-1:0] L_CONG = TW'(T_CONGEST);

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_timer;
    logic [TW:0]   w_timer_p1;
    logic          w_yel_done;
    logic          w_gmin_ok;
    logic          w_gmax_ok;
    logic [3:0]    w_preq;
    logic [TW-1:0] r_wait     [4];
    logic [TW-1:0] w_wait_nxt [4];
    logic [3:0]    w_green;
    logic [3:0]    w_cong_nxt;
    logic [1:0]    r_vel;
    logic [1:0]    w_vel_nxt;

    function automatic state_t green_of(input logic [1:0] p);
        case (p)
            2'd0:    return G0;
            2'd1:    return G1;
            default: return G2;
        endcase
    endfunction

    // Round-robin pick starting after phase k; with nobody waiting, advance to k+1.
    function automatic state_t next_green(input logic [1:0] k, input logic [3:0] pr);
        logic [1:0] p1;
        logic [1:0] p2;
        p1 = (k == 2'd2) ? 2'd0 : k + 2'd1;
        p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        if (pr[p1])      return green_of(p1);
        else if (pr[p2]) return green_of(p2);
        else if (pr[k])  return green_of(k);
        else             return green_of(p1);
    endfunction

    // Timer compares use timer+1 so thresholds of zero do not wrap.
    assign w_timer_p1 = {1'b0, r_timer} + (TW+1)'(1);
    assign w_yel_done = (w_timer_p1 == L_YEL);
    assign w_gmin_ok  = (w_timer_p1 >= L_GMIN);
    assign w_gmax_ok  = (w_timer_p1 >= L_GMAX);
    assign w_preq     = {1'b0, req[0], req[1], req[3] | req[2]};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ALL_RED: if (w_yel_done) w_next_state = next_green(2'd2, w_preq);
            G0: if (w_gmin_ok && (w_preq[1] | w_preq[2]) && (!w_preq[0] || w_gmax_ok))
                    w_next_state = Y0;
            G1: if (w_gmin_ok && (w_preq[0] | w_preq[2]) && (!w_preq[1] || w_gmax_ok))
                    w_next_state = Y1;
            G2: if (w_gmin_ok && (w_preq[0] | w_preq[1]) && (!w_preq[2] || w_gmax_ok))
                    w_next_state = Y2;
            Y0: if (w_yel_done) w_next_state = next_green(2'd0, w_preq);
            Y1: if (w_yel_done) w_next_state = next_green(2'd1, w_preq);
            Y2: if (w_yel_done) w_next_state = next_green(2'd2, w_preq);
            default: w_next_state = ALL_RED;
        endcase
    end

    assign w_green = {r_state == G0, r_state == G0, r_state == G1, r_state == G2};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_wait_nxt[i] = r_wait[i];
            if (!req[i])
                w_wait_nxt[i] = '0;
            else if (!w_green[i] && (r_wait[i] < L_CONG))
                w_wait_nxt[i] = r_wait[i] + TW'(1);
            w_cong_nxt[i] = (w_wait_nxt[i] == L_CONG);
        end
    end

    always_comb begin
        w_vel_nxt = 2'b00;
        case (w_next_state)
            G0:      w_vel_nxt = {w_cong_nxt[3], w_cong_nxt[2]};
            G1:      w_vel_nxt = {1'b0, w_cong_nxt[1]};
            G2:      w_vel_nxt = {1'b0, w_cong_nxt[0]};
            default: w_vel_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_10Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ALL_RED;
            r_timer <= '0;
            r_vel   <= 2'b00;
            for (int i = 0; i < 4; i++) r_wait[i] <= '0;
        end else begin
            r_state <= w_next_state;
            r_vel   <= w_vel_nxt;
            if (w_next_state != r_state)
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + TW'(1);
            for (int i = 0; i < 4; i++) r_wait[i] <= w_wait_nxt[i];
        end
    end

    assign tfst = r_state;
    assign vel  = r_vel;

endmodule
